mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//   Moore FSM sequencing the shared multicycle MIPS datapath (single memory, single ALU, IR, PC).
//   Decodes IR opcode/funct, walks each instruction through FETCH..writeback, drives every datapath
//   select/enable, counts retired instructions. Instantiated once inside processor, beside the datapath.
// PARAMETERS
//   RETIRE_W   32   width of retire_count; wraps modulo 2**RETIRE_W
// PORTS
//   clk           in   1         single clock, rising edge
//   reset         in   1         asynchronous, active-low reset (0 = in reset)
//   opcode        in   6         IR[31:26]
//   funct         in   6         IR[5:0]
//   zero          in   1         ALU zero flag
//   mem_ready     in   1         memory done; used only with MC_CTRL_MEM_WAIT_EN, else ignored
//   pc_write      out  1         PC load enable (branch-qualified in BRANCH)
//   iord          out  1         mem addr select: 0=PC, 1=ALUOut
//   mem_write     out  1         memory write enable
//   ir_write      out  1         IR load enable
//   reg_dst       out  1         dest reg: 0=rt, 1=rd
//   mem_to_reg    out  1         writeback data: 0=ALUOut, 1=MDR
//   reg_write     out  1         register file write enable
//   alu_src_a     out  1         0=PC, 1=A
//   alu_src_b     out  2         00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   alu_ctrl      out  3         000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   pc_src        out  2         00=ALU result, 01=ALUOut, 10=jump target
//   state         out  4         current state encoding (debug)
//   instr_retired out  1         high during final state of a completed instruction
//   illegal_op    out  1         high for one cycle on unsupported opcode/funct
//   retire_count  out  RETIRE_W  retired-instruction counter
// BEHAVIOUR
//   Reset (reset=0, async): state=FETCH, retire_count=0; while reset=0 all enables (pc_write,
//   mem_write, ir_write, reg_write), instr_retired, illegal_op forced 0. Reset mid-instruction aborts it.
//   Unlisted outputs 0 in each state. States/outputs -> next:
//   FETCH   iord=0 srcA=0 srcB=01 ADD pc_src=00 ir_write=1 pc_write=1 -> DECODE
//   DECODE  srcA=0 srcB=11 ADD (branch target to ALUOut). opcode 0x23/0x2B->MEMADR, 0x00->EXECUTE,
//           0x04->BRANCH, 0x08->ADDIEX, 0x02->JUMP; other: illegal_op=1 -> FETCH
//   MEMADR  srcA=1 srcB=10 ADD -> MEMRD (0x23) / MEMWR (0x2B)
//   MEMRD   iord=1 -> MEMWB;  MEMWB reg_dst=0 mem_to_reg=1 reg_write=1, retire -> FETCH
//   MEMWR   iord=1 mem_write=1, retire -> FETCH
//   EXECUTE srcA=1 srcB=00, alu_ctrl by funct: 0x20 ADD,0x22 SUB,0x24 AND,0x25 OR,0x2A SLT -> ALUWB;
//           unknown funct: illegal_op=1, no writeback -> FETCH
//   ALUWB   reg_dst=1 mem_to_reg=0 reg_write=1, retire -> FETCH
//   BRANCH  srcA=1 srcB=00 SUB pc_src=01 pc_write=zero, retire -> FETCH
//   ADDIEX  srcA=1 srcB=10 ADD -> ADDIWB;  ADDIWB reg_dst=0 reg_write=1, retire -> FETCH
//   JUMP    pc_src=10 pc_write=1, retire -> FETCH
//   Cycles/instr: lw 5, sw 4, R 4, addi 4, beq 3, j 3; illegal 2, not retired.
//   "retire": instr_retired=1 in that state; retire_count increments on its exiting edge, wraps to 0.
//   Outputs combinational from registered state (+zero, funct); no state change except on clk edge.
// CONFIGURATION
//   MC_CTRL_MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold while mem_ready=0; in FETCH ir_write and
//     pc_write asserted only when mem_ready=1; MEMWR mem_write stays high while holding; retire only
//     counted on the cycle MEMWR exits. Undefined: mem_ready ignored, fixed single-cycle memory.
// STRUCTURE
//   Package mips_ctrl_pkg: state_t enum (4-bit), opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//   OP_ADDI, OP_J), funct localparams, alu_ctrl encodings, alu_src_b/pc_src encodings.
//   Sub-module mips_alu_decoder: combinational funct -> {alu_ctrl, funct_valid}; FSM owns sequencing.
// TESTING
//   reset=0 mid-MEMRD -> state=FETCH, all write enables 0, retire_count=0 immediately (async)
//   lw (0x23) -> FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 clks; reg_write=1 & mem_to_reg=1 only in MEMWB
//   R add funct 0x20 -> alu_ctrl=010 in EXECUTE, reg_dst=1 in ALUWB; funct 0x3F -> illegal_op, no reg_write
//   beq zero=1 -> pc_write=1 pc_src=01 in BRANCH; zero=0 -> pc_write=0; both retire after 3 clks
//   opcode 0x3F -> illegal_op=1 one cycle in DECODE, back to FETCH, retire_count unchanged
//   RETIRE_W=4, 16 j instrs -> retire_count wraps 15->0; with MC_CTRL_MEM_WAIT_EN, mem_ready=0 for
//   3 clks in MEMWR -> mem_write held 4 clks, single retire

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
/*----------------------------------------------------------------------------
 * mips_ctrl_pkg : shared encodings for the multicycle MIPS controller
 * Rev 1.0 - initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
/*----------------------------------------------------------------------------
 * mips_multicycle_ctrl_if : controller <-> datapath signal bundle
 * Rev 1.0 - initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

interface mips_multicycle_ctrl_if #(
  parameter int RETIRE_W = 32
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                iord;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_ctrl;
  logic [1:0]          pc_src;
  logic [3:0]          state;
  logic                instr_retired;
  logic                illegal_op;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state, instr_retired,
           illegal_op, retire_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state, instr_retired,
           illegal_op, retire_count
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
/*----------------------------------------------------------------------------
 * mips_alu_decoder : R-type funct -> ALU operation plus validity flag
 * Rev 1.0 - initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_ctrl_o    = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
/*----------------------------------------------------------------------------
 * mips_multicycle_ctrl : Moore FSM sequencing the multicycle MIPS datapath
 * Optional MC_CTRL_MEM_WAIT_EN: stall FETCH/MEMRD/MEMWR on mem_ready.
 * Rev 1.0 - initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_multicycle_ctrl_if.master       bus
);

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retire_count_q;

  logic       pc_write, iord, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       retired, illegal;

  logic [2:0] dec_alu_ctrl;
  logic       dec_funct_valid;

  mips_alu_decoder u_alu_decoder (
    .funct_i       (bus.funct),
    .alu_ctrl_o    (dec_alu_ctrl),
    .funct_valid_o (dec_funct_valid)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  logic mem_ok;
  assign mem_ok = bus.mem_ready;
`else
  logic mem_ok;
  logic unused_mem_ready;
  assign mem_ok           = 1'b1;
  assign unused_mem_ready = bus.mem_ready;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctrl   = ALU_AND;
    pc_src     = PCSRC_ALU;
    retired    = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut for BRANCH to use.
        alu_src_b = SRCB_IMM_SH;
        alu_ctrl  = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retired    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        // Only the exiting cycle counts, so a stalled store retires once.
        if (mem_ok) begin
          retired = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_ctrl  = dec_alu_ctrl;
        if (dec_funct_valid) begin
          state_d = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = bus.zero;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retired  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       retire_count_q <= '0;
    else if (retired) retire_count_q <= retire_count_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
  end

  // Reset is asynchronous, so enables are masked combinationally as well.
  assign bus.pc_write      = pc_write  & reset;
  assign bus.mem_write     = mem_write & reset;
  assign bus.ir_write      = ir_write  & reset;
  assign bus.reg_write     = reg_write & reset;
  assign bus.instr_retired = retired   & reset;
  assign bus.illegal_op    = illegal   & reset;
  assign bus.iord          = iord;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_ctrl      = alu_ctrl;
  assign bus.pc_src        = pc_src;
  assign bus.state         = state_q;
  assign bus.retire_count  = retire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
/*----------------------------------------------------------------------------
 * tb_mips_multicycle_ctrl : directed self-checking bench for the controller
 * Rev 1.0 - initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_multicycle_ctrl_if #(.RETIRE_W(RW)) bus ();

  mips_multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check FETCH outputs, load opcode/funct, advance into DECODE and check it.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    chk("fetch_state", bus.state, 32'(S_FETCH));
    chk("fetch_irw", bus.ir_write, 1);
    chk("fetch_pcw", bus.pc_write, 1);
    chk("fetch_srcb", bus.alu_src_b, 1);
    bus.opcode = op;
    bus.funct  = fn;
    tick();
    chk("dec_state", bus.state, 32'(S_DECODE));
    chk("dec_srcb", bus.alu_src_b, 3);
    chk("dec_alu", bus.alu_ctrl, 3'b010);
    chk("dec_pcw", bus.pc_write, 0);
  endtask

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] al_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_state", bus.state, 32'(S_FETCH));
    chk("rst_pcw", bus.pc_write, 0);
    chk("rst_irw", bus.ir_write, 0);
    chk("rst_cnt", bus.retire_count, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;

    // lw: 5 cycles
    fetch_decode(6'h23, 6'h00);
    tick();
    chk("lw_memadr", bus.state, 32'(S_MEMADR));
    chk("lw_srca", bus.alu_src_a, 1);
    chk("lw_srcb", bus.alu_src_b, 2);
    tick();
    chk("lw_memrd", bus.state, 32'(S_MEMRD));
    chk("lw_iord", bus.iord, 1);
    chk("lw_rd_regw", bus.reg_write, 0);
    tick();
    chk("lw_memwb", bus.state, 32'(S_MEMWB));
    chk("lw_regw", bus.reg_write, 1);
    chk("lw_m2r", bus.mem_to_reg, 1);
    chk("lw_regdst", bus.reg_dst, 0);
    chk("lw_ret", bus.instr_retired, 1);
    tick();
    chk("lw_cnt", bus.retire_count, 1);

    // R-type: each funct maps to its ALU op, 4 cycles
    for (int i = 0; i < 5; i++) begin
      fetch_decode(6'h00, fn_tab[i]);
      tick();
      chk("r_exec", bus.state, 32'(S_EXECUTE));
      chk("r_alu", bus.alu_ctrl, al_tab[i]);
      chk("r_srca", bus.alu_src_a, 1);
      chk("r_srcb", bus.alu_src_b, 0);
      tick();
      chk("r_aluwb", bus.state, 32'(S_ALUWB));
      chk("r_regdst", bus.reg_dst, 1);
      chk("r_regw", bus.reg_write, 1);
      chk("r_m2r", bus.mem_to_reg, 0);
      chk("r_ret", bus.instr_retired, 1);
      tick();
      chk("r_cnt", bus.retire_count, 2 + i);
    end

    // R-type illegal funct
    fetch_decode(6'h00, 6'h3F);
    tick();
    chk("rbad_exec", bus.state, 32'(S_EXECUTE));
    chk("rbad_ill", bus.illegal_op, 1);
    chk("rbad_regw", bus.reg_write, 0);
    chk("rbad_ret", bus.instr_retired, 0);
    tick();
    chk("rbad_fetch", bus.state, 32'(S_FETCH));
    chk("rbad_cnt", bus.retire_count, 6);

    // beq taken then not taken
    bus.zero = 1'b1;
    fetch_decode(6'h04, 6'h00);
    tick();
    chk("beq1_state", bus.state, 32'(S_BRANCH));
    chk("beq1_pcw", bus.pc_write, 1);
    chk("beq1_pcsrc", bus.pc_src, 1);
    chk("beq1_alu", bus.alu_ctrl, 3'b110);
    chk("beq1_ret", bus.instr_retired, 1);
    tick();
    chk("beq1_cnt", bus.retire_count, 7);
    bus.zero = 1'b0;
    fetch_decode(6'h04, 6'h00);
    tick();
    chk("beq0_pcw", bus.pc_write, 0);
    chk("beq0_pcsrc", bus.pc_src, 1);
    chk("beq0_ret", bus.instr_retired, 1);
    tick();
    chk("beq0_cnt", bus.retire_count, 8);

    // illegal opcode: 2 cycles, no retire
    chk("ill_fetch0", bus.state, 32'(S_FETCH));
    bus.opcode = 6'h3F;
    tick();
    chk("ill_dec", bus.state, 32'(S_DECODE));
    chk("ill_flag", bus.illegal_op, 1);
    tick();
    chk("ill_back", bus.state, 32'(S_FETCH));
    chk("ill_flag_off", bus.illegal_op, 0);
    chk("ill_cnt", bus.retire_count, 8);

    // sw: 4 cycles
    fetch_decode(6'h2B, 6'h00);
    tick();
    chk("sw_memadr", bus.state, 32'(S_MEMADR));
    tick();
    chk("sw_memwr", bus.state, 32'(S_MEMWR));
    chk("sw_memw", bus.mem_write, 1);
    chk("sw_iord", bus.iord, 1);
    chk("sw_ret", bus.instr_retired, 1);
    tick();
    chk("sw_cnt", bus.retire_count, 9);

    // addi: 4 cycles
    fetch_decode(6'h08, 6'h00);
    tick();
    chk("addi_ex", bus.state, 32'(S_ADDIEX));
    chk("addi_srcb", bus.alu_src_b, 2);
    chk("addi_alu", bus.alu_ctrl, 3'b010);
    tick();
    chk("addi_wb", bus.state, 32'(S_ADDIWB));
    chk("addi_regw", bus.reg_write, 1);
    chk("addi_regdst", bus.reg_dst, 0);
    chk("addi_m2r", bus.mem_to_reg, 0);
    tick();
    chk("addi_cnt", bus.retire_count, 10);

    // 16 jumps: the 4-bit counter wraps 15 -> 0 and returns to 10
    for (int k = 0; k < 16; k++) begin
      fetch_decode(6'h02, 6'h00);
      tick();
      chk("j_state", bus.state, 32'(S_JUMP));
      chk("j_pcw", bus.pc_write, 1);
      chk("j_pcsrc", bus.pc_src, 2);
      chk("j_ret", bus.instr_retired, 1);
      tick();
      chk("j_cnt", bus.retire_count, (11 + k) % 16);
    end

    // asynchronous reset in the middle of MEMRD
    fetch_decode(6'h23, 6'h00);
    tick();
    tick();
    chk("abort_pre", bus.state, 32'(S_MEMRD));
    #2;
    reset = 1'b0;
    #1;
    chk("abort_state", bus.state, 32'(S_FETCH));
    chk("abort_cnt", bus.retire_count, 0);
    chk("abort_pcw", bus.pc_write, 0);
    chk("abort_irw", bus.ir_write, 0);
    chk("abort_regw", bus.reg_write, 0);
    chk("abort_memw", bus.mem_write, 0);
    tick();
    reset = 1'b1;
    #1;

`ifdef MC_CTRL_MEM_WAIT_EN
    // store stalled 3 cycles in MEMWR
    fetch_decode(6'h2B, 6'h00);
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      chk("wait_state", bus.state, 32'(S_MEMWR));
      chk("wait_memw", bus.mem_write, 1);
      chk("wait_ret", bus.instr_retired, 0);
      tick();
    end
    chk("wait_hold", bus.state, 32'(S_MEMWR));
    bus.mem_ready = 1'b1;
    #1;
    chk("wait_memw_last", bus.mem_write, 1);
    chk("wait_ret_last", bus.instr_retired, 1);
    tick();
    chk("wait_exit", bus.state, 32'(S_FETCH));
    chk("wait_cnt", bus.retire_count, 1);
`else
    // mem_ready is ignored: store still takes 4 cycles
    bus.mem_ready = 1'b0;
    #1;
    fetch_decode(6'h2B, 6'h00);
    tick();
    tick();
    chk("nowait_memwr", bus.state, 32'(S_MEMWR));
    chk("nowait_memw", bus.mem_write, 1);
    tick();
    chk("nowait_fetch", bus.state, 32'(S_FETCH));
    chk("nowait_cnt", bus.retire_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
